// File: rtl/f2_cmd_exec.sv
// Grid walker: executes single-step move/rotate commands and a timed navigate-home walk.
// Define F2_GRID_WRAP_EN to wrap coordinates at the grid edges instead of saturating.
module f2_cmd_exec #(
    parameter int STEP_DIV = 4,
    parameter int GRID_MAX = 15
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       set,
    input  logic [2:0] instruction,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic [1:0] heading,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_NAV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] INS_FWD  = 3'd1;
    localparam logic [2:0] INS_BWD  = 3'd2;
    localparam logic [2:0] INS_ROT  = 3'd3;
    localparam logic [2:0] INS_HOME = 3'd4;
    localparam logic [3:0] P_MAX    = 4'(GRID_MAX);
    localparam logic [7:0] CNT_LOAD = 8'(STEP_DIV - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_set_q;
    logic [2:0] r_instr;
    logic [7:0] r_cnt;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic [1:0] r_hd;

    logic       w_accept;
    logic       w_at_origin;
    logic [1:0] w_dir;
    logic [3:0] w_nx;
    logic [3:0] w_ny;

    function automatic logic [3:0] f_inc(input logic [3:0] v);
`ifdef F2_GRID_WRAP_EN
        return (v == P_MAX) ? 4'd0 : v + 4'd1;
`else
        return (v == P_MAX) ? v : v + 4'd1;
`endif
    endfunction

    function automatic logic [3:0] f_dec(input logic [3:0] v);
`ifdef F2_GRID_WRAP_EN
        return (v == 4'd0) ? P_MAX : v - 4'd1;
`else
        return (v == 4'd0) ? v : v - 4'd1;
`endif
    endfunction

    assign w_accept    = set && !r_set_q && (r_state == S_IDLE);
    assign w_at_origin = (r_x == 4'd0) && (r_y == 4'd0);

    // Backward moves along the opposite compass direction.
    assign w_dir = (r_instr == INS_BWD) ? (r_hd ^ 2'd2) : r_hd;

    always_comb begin
        w_nx = r_x;
        w_ny = r_y;
        case (w_dir)
            2'd0:    w_ny = f_inc(r_y);
            2'd1:    w_nx = f_inc(r_x);
            2'd2:    w_ny = f_dec(r_y);
            default: w_nx = f_dec(r_x);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (instruction == INS_HOME)
                        w_state_nxt = S_NAV;
                    else if (instruction == INS_FWD || instruction == INS_BWD ||
                             instruction == INS_ROT)
                        w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:  w_state_nxt = S_DONE;
            S_NAV:   if (w_at_origin) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_set_q <= 1'b0;
            r_instr <= 3'd0;
            r_cnt   <= 8'd0;
            r_x     <= 4'd0;
            r_y     <= 4'd0;
            r_hd    <= 2'd0;
        end else begin
            r_set_q <= set;
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_instr <= instruction;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                S_EXEC: begin
                    if (r_instr == INS_ROT) begin
                        r_hd <= r_hd + 2'd1;
                    end else begin
                        r_x <= w_nx;
                        r_y <= w_ny;
                    end
                end
                S_NAV: begin
                    // Walk x to zero first, then y, one cell per STEP_DIV cycles.
                    if (!w_at_origin) begin
                        if (r_cnt == 8'd0) begin
                            r_cnt <= CNT_LOAD;
                            if (r_x != 4'd0)
                                r_x <= r_x - 4'd1;
                            else
                                r_y <= r_y - 4'd1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pos_x   = r_x;
    assign pos_y   = r_y;
    assign heading = r_hd;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_f2_cmd_exec.sv
// Directed bench for f2_cmd_exec (default STEP_DIV=4, GRID_MAX=15); honours F2_GRID_WRAP_EN.
module tb_f2_cmd_exec;

    logic       sysclk;
    logic       rst_n;
    logic       set;
    logic [2:0] instruction;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic [1:0] heading;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;

    f2_cmd_exec dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .set         (set),
        .instruction (instruction),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .heading     (heading),
        .busy        (busy),
        .done        (done)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Drive one rising edge of set with the given instruction, return one negedge later.
    task automatic issue(input logic [2:0] ins);
        set = 1'b1;
        instruction = ins;
        tick(1);
        set = 1'b0;
        instruction = 3'd0;
    endtask

    task automatic cmd(input logic [2:0] ins);
        issue(ins);
        tick(2);
    endtask

    logic [3:0] exp_x;
    logic [3:0] sv_x;

    initial begin
        rst_n = 1'b0;
        set = 1'b0;
        instruction = 3'd0;
        #2;
        chk("rst_x", pos_x, 0);
        chk("rst_y", pos_y, 0);
        chk("rst_hd", heading, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // single forward
        issue(3'd1);
        chk("fwd_busy1", busy, 1);
        chk("fwd_y_early", pos_y, 0);
        tick(1);
        chk("fwd_y", pos_y, 1);
        chk("fwd_done", done, 1);
        chk("fwd_busy2", busy, 1);
        tick(1);
        chk("fwd_busy_end", busy, 0);
        chk("fwd_done_end", done, 0);
        chk("fwd_done_cnt", done_cnt, 1);

        // rotations
        for (int i = 1; i <= 4; i++) begin
            cmd(3'd3);
            chk("rot_hd", heading, i % 4);
        end
        set = 1'b1;
        instruction = 3'd3;
        tick(10);
        set = 1'b0;
        instruction = 3'd0;
        tick(3);
        chk("rot_held", heading, 1);
        chk("rot_done_cnt", done_cnt, 6);

        // walk to (3,2) facing N
        repeat (3) cmd(3'd1);
        chk("walk_x", pos_x, 3);
        chk("walk_hd", heading, 1);
        repeat (3) cmd(3'd3);
        cmd(3'd1);
        chk("walk_y", pos_y, 2);
        chk("walk_hd0", heading, 0);

        // navigate home
        issue(3'd4);
        chk("nav_busy", busy, 1);
        tick(3);
        set = 1'b1;
        instruction = 3'd1;
        tick(1);
        set = 1'b0;
        instruction = 3'd0;
        chk("nav_x_n5", pos_x, 2);
        tick(7);
        chk("nav_x_n12", pos_x, 1);
        tick(1);
        chk("nav_x_n13", pos_x, 0);
        chk("nav_y_n13", pos_y, 2);
        tick(8);
        chk("nav_y_n21", pos_y, 0);
        chk("nav_busy_n21", busy, 1);
        chk("nav_nodone_n21", done, 0);
        tick(1);
        chk("nav_done", done, 1);
        tick(1);
        chk("nav_idle", busy, 0);
        chk("nav_hd", heading, 0);
        tick(2);
        chk("nav_ignored_edge", busy, 0);
        chk("nav_done_cnt", done_cnt, 14);

        // edge rule at origin facing W
        repeat (3) cmd(3'd3);
        cmd(3'd1);
`ifdef F2_GRID_WRAP_EN
        exp_x = 4'd15;
`else
        exp_x = 4'd0;
`endif
        chk("edge_fwd_x", pos_x, exp_x);
        chk("edge_hd", heading, 3);
        cmd(3'd2);
        exp_x = exp_x + 4'd1;
        chk("edge_bwd_x", pos_x, exp_x);
        chk("edge_done_cnt", done_cnt, 19);

        // reserved instruction
        sv_x = pos_x;
        issue(3'd6);
        chk("rsv_busy", busy, 0);
        tick(1);
        chk("rsv_done", done, 0);
        tick(1);
        chk("rsv_x", pos_x, sv_x);
        chk("rsv_hd", heading, 3);
        chk("rsv_done_cnt", done_cnt, 19);

        // reset mid-navigate from (5,5)
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        repeat (5) cmd(3'd1);
        cmd(3'd3);
        repeat (5) cmd(3'd1);
        chk("r37_x", pos_x, 5);
        chk("r37_y", pos_y, 5);
        issue(3'd4);
        tick(5);
        chk("r37_nav_x", pos_x, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r37_async_x", pos_x, 0);
        chk("r37_async_y", pos_y, 0);
        chk("r37_async_hd", heading, 0);
        chk("r37_async_busy", busy, 0);
        chk("r37_async_done", done, 0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("r37_idle", busy, 0);
        chk("r37_done_cnt", done_cnt, 30);

        // set already high at reset release counts as a rising edge
        rst_n = 1'b0;
        set = 1'b1;
        instruction = 3'd3;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("r29_busy", busy, 1);
        tick(1);
        chk("r29_hd", heading, 1);
        chk("r29_done", done, 1);
        set = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
